// File: rtl/audio_level_meter_if.sv
// Sample FIFO read-port bundle between the dual-clock audio FIFO and the level meter.
//   fifo_q       : FIFO read data, valid the cycle after fifo_rdreq
//   fifo_rdempty : FIFO empty, read-clock domain
//   fifo_rdfull  : FIFO full, read-clock domain
//   fifo_rdreq   : one-cycle read request per word
// master = consumer issuing read requests, slave = FIFO read port.
interface audio_level_meter_if;
  logic [31:0] fifo_q;
  logic        fifo_rdempty;
  logic        fifo_rdfull;
  logic        fifo_rdreq;

  modport master (
    output fifo_rdreq,
    input  fifo_q,
    input  fifo_rdempty,
    input  fifo_rdfull
  );

  modport slave (
    input  fifo_rdreq,
    output fifo_q,
    output fifo_rdempty,
    output fifo_rdfull
  );
endinterface

// File: rtl/audio_level_meter.sv
// Audio level meter: drains the sample FIFO (CLOCK_50 read side), splits each
// word into signed left/right samples, tracks per-channel peak magnitude over
// WINDOW samples and publishes decaying peak-hold bar levels at window end.
// Ports:
//   clk          : system clock, rising edge
//   reset_n      : synchronous active-low reset
//   enable       : 1 = drain FIFO; 0 = finish in-flight word, then idle
//   fifo         : FIFO read-port bundle (master side)
//   level_l/_r   : displayed bar levels
//   level_valid  : one-cycle pulse when level_l/level_r update
//   overrun      : sticky, set when fifo_rdfull is seen while enabled
//   overrun_clr  : clears overrun; a simultaneous set wins
//
// state   | meaning
// IDLE    | wait for enable and a non-empty FIFO
// POP     | fifo_rdreq asserted for this single cycle
// CAPTURE | fifo_q valid, register left/right samples
// UPDATE  | fold magnitudes into peaks, advance window, publish at window end
module audio_level_meter #(
  parameter int SAMPLE_W = 16,
  parameter int LEVEL_W  = 8,
  parameter int WINDOW   = 1024,
  parameter int DECAY    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  audio_level_meter_if.master       fifo,
  output logic [LEVEL_W-1:0]        level_l,
  output logic [LEVEL_W-1:0]        level_r,
  output logic                      level_valid,
  output logic                      overrun,
  input  logic                      overrun_clr
);

  localparam int MAG_W = SAMPLE_W - 1;
  localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_POP     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_UPDATE  = 2'd3;

  logic [1:0]          state;
  logic [SAMPLE_W-1:0] sample_l, sample_r;
  logic [MAG_W-1:0]    peak_l, peak_r;
  logic [CNT_W-1:0]    count;

  logic [MAG_W-1:0]    mag_l, mag_r;
  logic [MAG_W-1:0]    peak_l_next, peak_r_next;
  logic [LEVEL_W-1:0]  new_l, new_r;
  logic [LEVEL_W-1:0]  disp_l_next, disp_r_next;
  logic                window_last;

  // |s| with the most negative code clamped to the largest positive magnitude.
  function automatic logic [MAG_W-1:0] sat_mag(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] a;
    a = s[SAMPLE_W-1] ? (~s + 1'b1) : s;
    if (a[SAMPLE_W-1])
      return {MAG_W{1'b1}};
    else
      return a[MAG_W-1:0];
  endfunction

  // Peak-hold with linear fall: snap up, otherwise drop by DECAY but never below the new level.
  // Threshold is computed one bit wider so new + DECAY cannot wrap.
  function automatic logic [LEVEL_W-1:0] decay_step(input logic [LEVEL_W-1:0] cur,
                                                    input logic [LEVEL_W-1:0] nw);
    logic [LEVEL_W:0] thresh;
    thresh = {1'b0, nw} + (LEVEL_W+1)'(DECAY);
    if (nw >= cur)
      return nw;
    else if ({1'b0, cur} > thresh)
      return cur - LEVEL_W'(DECAY);
    else
      return nw;
  endfunction

  assign fifo.fifo_rdreq = (state == ST_POP);

  always_comb begin
    mag_l       = sat_mag(sample_l);
    mag_r       = sat_mag(sample_r);
    peak_l_next = (mag_l > peak_l) ? mag_l : peak_l;
    peak_r_next = (mag_r > peak_r) ? mag_r : peak_r;
    new_l       = peak_l_next[MAG_W-1 -: LEVEL_W];
    new_r       = peak_r_next[MAG_W-1 -: LEVEL_W];
    disp_l_next = decay_step(level_l, new_l);
    disp_r_next = decay_step(level_r, new_r);
    window_last = (count == CNT_W'(WINDOW - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      sample_l    <= '0;
      sample_r    <= '0;
      peak_l      <= '0;
      peak_r      <= '0;
      count       <= '0;
      level_l     <= '0;
      level_r     <= '0;
      level_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      level_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (enable && !fifo.fifo_rdempty)
            state <= ST_POP;
        end
        // rdempty is deliberately not re-checked here: the word was committed in IDLE.
        ST_POP: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          sample_l <= fifo.fifo_q[31 -: SAMPLE_W];
          sample_r <= fifo.fifo_q[15 -: SAMPLE_W];
          state    <= ST_UPDATE;
        end
        ST_UPDATE: begin
          state <= ST_IDLE;
          if (window_last) begin
            // Final sample is already folded into new_l/new_r; restart window with no gap.
            level_l     <= disp_l_next;
            level_r     <= disp_r_next;
            level_valid <= 1'b1;
            peak_l      <= '0;
            peak_r      <= '0;
            count       <= '0;
          end else begin
            peak_l <= peak_l_next;
            peak_r <= peak_r_next;
            count  <= count + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (enable && fifo.fifo_rdfull)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_level_meter.sv
module tb_audio_level_meter;
  localparam int WIN = 4;
  localparam int DEC = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       overrun_clr;
  logic [7:0] level_l, level_r;
  logic       level_valid;
  logic       overrun;

  always #5 clk = ~clk;

  audio_level_meter_if bus ();

  audio_level_meter #(
    .SAMPLE_W(16), .LEVEL_W(8), .WINDOW(WIN), .DECAY(DEC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .fifo        (bus),
    .level_l     (level_l),
    .level_r     (level_r),
    .level_valid (level_valid),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // FIFO model and reference model state
  logic [31:0] fifo_mem[$];
  bit          rd_seen = 1'b0;
  logic [31:0] win_q[$];
  int          disp_l, disp_r;
  bit          ov_exp;
  int          last_rd;
  int          rd_count;

  typedef struct {
    int due;
    int l;
    int r;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [31:0] w[4];
    int          l;
    int          r;
  } vec_t;
  vec_t tbl[5];

  function automatic int mag_of(input logic [15:0] s);
    int v;
    v = int'($signed(s));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  // bar level = magnitude scaled to 8 bits (15-bit magnitude / 128)
  function automatic int lvl_of(input int m);
    return m / 128;
  endfunction

  function automatic int step(input int cur, input int nw);
    if (nw >= cur) return nw;
    if (cur > nw + DEC) return cur - DEC;
    return nw;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic model_clear();
    win_q.delete();
    exp_q.delete();
    disp_l  = 0;
    disp_r  = 0;
    ov_exp  = 1'b0;
    last_rd = -100;
  endtask

  task automatic cycle();
    bit rst_d, en_d, emp_d, full_d, clr_d;
    int ml, mr;
    exp_t e;
    rst_d  = reset_n;
    en_d   = enable;
    emp_d  = bus.fifo_rdempty;
    full_d = bus.fifo_rdfull;
    clr_d  = overrun_clr;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_seen && fifo_mem.size() > 0) bus.fifo_q = fifo_mem.pop_front();
    bus.fifo_rdempty = (fifo_mem.size() == 0);

    if (!rst_d) model_clear();
    else if (en_d && full_d) ov_exp = 1'b1;
    else if (clr_d) ov_exp = 1'b0;

    if (bus.fifo_rdreq === 1'b1) begin
      chk("rdreq_allowed", int'(rst_d && en_d && !emp_d), 1);
      chk("rdreq_spacing", int'((cyc - last_rd) >= 4), 1);
      last_rd = cyc;
      rd_count++;
      if (fifo_mem.size() > 0) win_q.push_back(fifo_mem[0]);
      if (win_q.size() == WIN) begin
        ml = 0;
        mr = 0;
        foreach (win_q[i]) begin
          if (mag_of(win_q[i][31:16]) > ml) ml = mag_of(win_q[i][31:16]);
          if (mag_of(win_q[i][15:0])  > mr) mr = mag_of(win_q[i][15:0]);
        end
        e.due = cyc + 3;
        e.l   = step(disp_l, lvl_of(ml));
        e.r   = step(disp_r, lvl_of(mr));
        exp_q.push_back(e);
        win_q.delete();
      end
    end

    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      disp_l = exp_q[0].l;
      disp_r = exp_q[0].r;
      void'(exp_q.pop_front());
      chk("level_valid", int'(level_valid), 1);
    end else begin
      chk("level_valid", int'(level_valid), 0);
    end
    chk("level_l", int'(level_l), disp_l);
    chk("level_r", int'(level_r), disp_r);
    chk("overrun", int'(overrun), int'(ov_exp));
    rd_seen = (bus.fifo_rdreq === 1'b1);
  endtask

  task automatic wait_pulse(input int budget);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (level_valid !== 1'b1 && n < budget);
    chk("pulse_timeout", int'(level_valid === 1'b1), 1);
  endtask

  task automatic wait_rd(input int target, input int budget);
    int n;
    n = 0;
    while (rd_count < target && n < budget) begin
      cycle();
      n++;
    end
    chk("rd_timeout", int'(rd_count >= target), 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    fifo_mem.delete();
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, cnt;
    reset_n          = 1'b0;
    enable           = 1'b1;
    overrun_clr      = 1'b0;
    bus.fifo_q       = '0;
    bus.fifo_rdfull  = 1'b0;
    bus.fifo_rdempty = 1'b0;
    model_clear();
    rd_count = 0;

    tbl[0].w = '{32'h1000_F000, 32'h4000_0100, 32'h0200_8000, 32'h0000_0000};
    tbl[0].l = 8'h80; tbl[0].r = 8'hFF;
    tbl[1].w = '{32'h0, 32'h0, 32'h0, 32'h0};
    tbl[1].l = 8'h7C; tbl[1].r = 8'hFB;
    tbl[2].w = '{32'h0, 32'h0, 32'h0, 32'h0};
    tbl[2].l = 8'h78; tbl[2].r = 8'hF7;
    tbl[3].w = '{32'h6000_0000, 32'h0, 32'h0, 32'h0000_C000};
    tbl[3].l = 8'hC0; tbl[3].r = 8'hF3;
    tbl[4].w = '{32'h0040_0010, 32'hFFC0_FFF0, 32'h0, 32'h0};
    tbl[4].l = 8'hBC; tbl[4].r = 8'hEF;

    // 1: reset held with words available and enable high
    for (int i = 0; i < 8; i++) fifo_mem.push_back($urandom);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("reset_rdreq", int'(bus.fifo_rdreq === 1'b1), 0);
    end
    chk("reset_level_l", int'(level_l), 0);
    chk("reset_overrun", int'(overrun), 0);
    fifo_mem.delete();
    cycle();
    reset_n = 1'b1;

    // 2: handshake cadence, then drained FIFO
    for (int i = 0; i < 40; i++) fifo_mem.push_back($urandom);
    prev = -1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (bus.fifo_rdreq === 1'b1) begin
        if (prev >= 0) chk("rd_gap", cyc - prev, 4);
        prev = cyc;
      end
    end
    cnt = 0;
    while (fifo_mem.size() > 0 && cnt < 400) begin cycle(); cnt++; end
    for (int i = 0; i < 8; i++) cycle();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.fifo_rdreq === 1'b1) cnt++;
    end
    chk("empty_no_rdreq", cnt, 0);

    // 3/4: table-driven windows
    do_reset();
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 4; k++) fifo_mem.push_back(tbl[v].w[k]);
      wait_pulse(60);
      chk("tbl_level_l", int'(level_l), tbl[v].l);
      chk("tbl_level_r", int'(level_r), tbl[v].r);
    end

    // 4: decay floors at zero, then snaps up
    for (int v = 0; v < 70; v++) begin
      for (int k = 0; k < 4; k++) fifo_mem.push_back(32'h0);
      wait_pulse(60);
    end
    chk("floor_l", int'(level_l), 0);
    chk("floor_r", int'(level_r), 0);
    for (int k = 0; k < 4; k++) fifo_mem.push_back(32'h0);
    wait_pulse(60);
    chk("floor_hold_r", int'(level_r), 0);
    fifo_mem.push_back(32'h7FFF_8001);
    for (int k = 0; k < 3; k++) fifo_mem.push_back(32'h0);
    wait_pulse(60);
    chk("snap_l", int'(level_l), 8'hFF);
    chk("snap_r", int'(level_r), 8'hFF);

    // 5: enable dropped during CAPTURE of the 3rd word
    do_reset();
    for (int k = 0; k < 8; k++) fifo_mem.push_back($urandom);
    rd_count = 0;
    wait_rd(3, 60);
    cycle();
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (bus.fifo_rdreq === 1'b1) cnt++;
    end
    chk("gated_rdreq", cnt, 0);
    chk("gated_count", rd_count, 3);
    enable = 1'b1;
    wait_pulse(40);
    chk("gated_total", rd_count, 4);

    // 6: overrun sticky / clear priority
    bus.fifo_rdfull = 1'b1;
    cycle();
    bus.fifo_rdfull = 1'b0;
    cycle();
    chk("ovr_sticky", int'(overrun), 1);
    overrun_clr = 1'b1;
    bus.fifo_rdfull = 1'b1;
    cycle();
    chk("ovr_set_wins", int'(overrun), 1);
    bus.fifo_rdfull = 1'b0;
    cycle();
    chk("ovr_cleared", int'(overrun), 0);
    overrun_clr = 1'b0;

    // 6: mid-window reset needs a full fresh window
    do_reset();
    for (int k = 0; k < 12; k++) fifo_mem.push_back($urandom);
    rd_count = 0;
    wait_rd(2, 60);
    cycle();
    reset_n = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    rd_count = 0;
    wait_pulse(80);
    chk("fresh_window", rd_count, 4);

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0 && fifo_mem.size() < 20) begin
        if ($urandom_range(0, 7) == 0) fifo_mem.push_back(32'h8000_8000);
        else fifo_mem.push_back($urandom);
      end
      enable          = ($urandom_range(0, 9) != 0);
      bus.fifo_rdfull = ($urandom_range(0, 49) == 0);
      overrun_clr     = ($urandom_range(0, 19) == 0);
      reset_n         = ($urandom_range(0, 499) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
